// File: rtl/buma_cmp_seq.sv
// Sequential MSB-first magnitude comparator, CHUNK bits per clock, signed or unsigned.
// Define BUMA_EARLY_EXIT_EN to finish on the first differing chunk instead of after NCHUNK steps.
module buma_cmp_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int STEP_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NCHUNK - 1);

`ifdef BUMA_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("buma_cmp_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_q, b_q, a_n, b_n;
    logic [STEP_W-1:0] step, step_n;
    logic              decided, decided_n;
    logic              busy_n, done_n, lt_n, eq_n, gt_n;
    logic [CHUNK-1:0]  chunk_a, chunk_b;
    logic              chunk_diff;
    logic              first_diff;

    assign chunk_a    = a_q[int'(step) * CHUNK +: CHUNK];
    assign chunk_b    = b_q[int'(step) * CHUNK +: CHUNK];
    assign chunk_diff = (chunk_a != chunk_b);
    assign first_diff = chunk_diff && !decided;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            step    <= '0;
            decided <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
        end else begin
            state   <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            step    <= step_n;
            decided <= decided_n;
            busy    <= busy_n;
            done    <= done_n;
            lt      <= lt_n;
            eq      <= eq_n;
            gt      <= gt_n;
        end
    end

    always_comb begin
        state_n   = state;
        a_n       = a_q;
        b_n       = b_q;
        step_n    = step;
        decided_n = decided;
        busy_n    = busy;
        done_n    = 1'b0;
        lt_n      = lt;
        eq_n      = eq;
        gt_n      = gt;

        case (state)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit turns two's-complement order into unsigned order.
                    a_n              = a;
                    b_n              = b;
                    a_n[WIDTH-1]     = a[WIDTH-1] ^ signed_mode;
                    b_n[WIDTH-1]     = b[WIDTH-1] ^ signed_mode;
                    step_n           = LAST_STEP;
                    decided_n        = 1'b0;
                    busy_n           = 1'b1;
                    lt_n             = 1'b0;
                    eq_n             = 1'b0;
                    gt_n             = 1'b0;
                    state_n          = RUN;
                end
            end

            RUN: begin
                if (first_diff) begin
                    lt_n      = (chunk_a < chunk_b);
                    gt_n      = (chunk_a > chunk_b);
                    decided_n = 1'b1;
                end
                if ((first_diff && EARLY_EXIT) || step == '0) begin
                    eq_n    = ~(decided | chunk_diff);
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    step_n = step - 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_buma_cmp_seq.sv
// Directed self-checking bench for buma_cmp_seq: a 16-bit/4-bit-chunk instance
// plus a 4-bit single-chunk instance for the one-cycle-latency boundary.
module tb_buma_cmp_seq;

    localparam int NCHUNK = 4;
`ifdef BUMA_EARLY_EXIT_EN
    localparam int TOP_DIFF_LAT = 1;
`else
    localparam int TOP_DIFF_LAT = NCHUNK;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, lt, eq, gt;

    logic        start4 = 1'b0;
    logic        signed_mode4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4, done4, lt4, eq4, gt4;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    buma_cmp_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
    );

    buma_cmp_seq #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .signed_mode(signed_mode4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4)
    );

    // Launch one compare on the 16-bit instance; lat = edges from accept to done.
    task automatic run_cmp(input logic sm, input logic [15:0] aa, input logic [15:0] bb,
                           output int lat, output int busy_cycles);
        @(posedge clk); #1;
        signed_mode = sm; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_cmp4(input logic sm, input logic [3:0] aa, input logic [3:0] bb,
                            output int lat);
        @(posedge clk); #1;
        signed_mode4 = sm; a4 = aa; b4 = bb; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs16: got %b expected 00000", {busy, done, lt, eq, gt});
        end
        n_checks++;
        if ({busy4, done4, lt4, eq4, gt4} !== 5'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs4: got %b expected 00000", {busy4, done4, lt4, eq4, gt4});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_chunk();
        int lat;
        run_cmp4(1'b1, 4'b0001, 4'b0101, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fails++;
            $display("[TB] FAIL single_chunk_latency: got %0d expected 1", lat);
        end
        n_checks++;
        if ({lt4, eq4, gt4} !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL single_chunk_flags: got %b expected 100", {lt4, eq4, gt4});
        end
        run_cmp4(1'b1, 4'b1000, 4'b0111, lat);
        n_checks++;
        if ({lt4, eq4, gt4} !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL single_chunk_signed_min_max: got %b expected 100", {lt4, eq4, gt4});
        end
        run_cmp4(1'b0, 4'b1000, 4'b0111, lat);
        n_checks++;
        if ({lt4, eq4, gt4} !== 3'b001) begin
            n_fails++;
            $display("[TB] FAIL single_chunk_unsigned: got %b expected 001", {lt4, eq4, gt4});
        end
    endtask

    task automatic test_signed_boundary();
        int lat, bc;
        run_cmp(1'b1, 16'h8000, 16'h7FFF, lat, bc);
        n_checks++;
        if (lat !== TOP_DIFF_LAT) begin
            n_fails++;
            $display("[TB] FAIL signed_boundary_latency: got %0d expected %0d", lat, TOP_DIFF_LAT);
        end
        n_checks++;
        if ({lt, eq, gt} !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL signed_boundary_flags: got %b expected 100", {lt, eq, gt});
        end
        run_cmp(1'b0, 16'h8000, 16'h7FFF, lat, bc);
        n_checks++;
        if ({lt, eq, gt} !== 3'b001) begin
            n_fails++;
            $display("[TB] FAIL unsigned_8000_vs_7fff: got %b expected 001", {lt, eq, gt});
        end
        run_cmp(1'b0, 16'hFFFF, 16'h0000, lat, bc);
        n_checks++;
        if ({lt, eq, gt} !== 3'b001) begin
            n_fails++;
            $display("[TB] FAIL unsigned_ones_vs_zero: got %b expected 001", {lt, eq, gt});
        end
        run_cmp(1'b1, 16'hFFFF, 16'h0001, lat, bc);
        n_checks++;
        if ({lt, eq, gt} !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL signed_minus1_vs_1: got %b expected 100", {lt, eq, gt});
        end
    endtask

    task automatic test_equal();
        int lat, bc;
        for (int m = 0; m < 2; m++) begin
            run_cmp(m[0], 16'hA5A5, 16'hA5A5, lat, bc);
            n_checks++;
            if (lat !== NCHUNK) begin
                n_fails++;
                $display("[TB] FAIL equal_latency_mode%0d: got %0d expected %0d", m, lat, NCHUNK);
            end
            n_checks++;
            if (bc !== NCHUNK) begin
                n_fails++;
                $display("[TB] FAIL equal_busy_cycles_mode%0d: got %0d expected %0d", m, bc, NCHUNK);
            end
            n_checks++;
            if ({lt, eq, gt} !== 3'b010) begin
                n_fails++;
                $display("[TB] FAIL equal_flags_mode%0d: got %b expected 010", m, {lt, eq, gt});
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, lt, eq, gt} !== 5'b00010) begin
            n_fails++;
            $display("[TB] FAIL equal_flags_hold: got %b expected 00010", {busy, done, lt, eq, gt});
        end
    endtask

    task automatic test_lower_chunks();
        int lat, bc;
        run_cmp(1'b0, 16'h1234, 16'h1235, lat, bc);
        n_checks++;
        if (lat !== NCHUNK) begin
            n_fails++;
            $display("[TB] FAIL low_chunk_latency: got %0d expected %0d", lat, NCHUNK);
        end
        n_checks++;
        if ({lt, eq, gt} !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL low_chunk_flags: got %b expected 100", {lt, eq, gt});
        end
        run_cmp(1'b0, 16'h2234, 16'h1FFF, lat, bc);
        n_checks++;
        if (lat !== TOP_DIFF_LAT) begin
            n_fails++;
            $display("[TB] FAIL top_chunk_latency: got %0d expected %0d", lat, TOP_DIFF_LAT);
        end
        n_checks++;
        if ({lt, eq, gt} !== 3'b001) begin
            n_fails++;
            $display("[TB] FAIL top_chunk_not_overridden: got %b expected 001", {lt, eq, gt});
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL done_single_pulse: got %b expected 0", done);
        end
    endtask

    // Start held high: compare 1 accepted at edge 0, compare 2 on the edge ending its done cycle.
    task automatic test_back_to_back();
        int first_done = -1;
        int second_done = -1;
        logic [2:0] flags1 = '0;
        logic [2:0] flags2 = '0;
        @(posedge clk); #1;
        signed_mode = 1'b0; a = 16'h1234; b = 16'h1235; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                a = 16'h0001; b = 16'h0000;
            end
            if (i == 6) begin
                a = 16'h0000; b = 16'h0001; signed_mode = 1'b1;
            end
            if (i == 5) begin
                n_checks++;
                if ({busy, lt, eq, gt} !== 4'b1000) begin
                    n_fails++;
                    $display("[TB] FAIL b2b_accept_clears: got %b expected 1000", {busy, lt, eq, gt});
                end
            end
            if (done === 1'b1) begin
                if (first_done < 0) begin
                    first_done = i; flags1 = {lt, eq, gt};
                end else if (second_done < 0) begin
                    second_done = i; flags2 = {lt, eq, gt};
                end
            end
            if (i == 9) start = 1'b0;
        end
        n_checks++;
        if (first_done !== NCHUNK) begin
            n_fails++;
            $display("[TB] FAIL b2b_first_done_edge: got %0d expected %0d", first_done, NCHUNK);
        end
        n_checks++;
        if (flags1 !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL b2b_first_flags: got %b expected 100", flags1);
        end
        n_checks++;
        if (second_done !== 2 * NCHUNK + 1) begin
            n_fails++;
            $display("[TB] FAIL b2b_second_done_edge: got %0d expected %0d", second_done, 2 * NCHUNK + 1);
        end
        n_checks++;
        if (flags2 !== 3'b001) begin
            n_fails++;
            $display("[TB] FAIL b2b_second_flags: got %b expected 001", flags2);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        logic saw_done = 1'b0;
        @(posedge clk); #1;
        signed_mode = 1'b0; a = 16'h1234; b = 16'h1235; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL mid_run_busy_before_reset: got %b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, lt, eq, gt} !== 5'b0) begin
            n_fails++;
            $display("[TB] FAIL async_reset_outputs: got %b expected 00000", {busy, done, lt, eq, gt});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL no_done_after_abort: got %b expected 0", saw_done);
        end
        run_cmp(1'b1, 16'h8000, 16'h7FFF, lat, bc);
        n_checks++;
        if (lat !== TOP_DIFF_LAT) begin
            n_fails++;
            $display("[TB] FAIL post_reset_latency: got %0d expected %0d", lat, TOP_DIFF_LAT);
        end
        n_checks++;
        if ({lt, eq, gt} !== 3'b100) begin
            n_fails++;
            $display("[TB] FAIL post_reset_flags: got %b expected 100", {lt, eq, gt});
        end
    endtask

    initial begin
        $display("[TB] starting buma_cmp_seq bench");
        test_reset();
        test_single_chunk();
        test_signed_boundary();
        test_equal();
        test_lower_chunks();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
